// File: rtl/synth_cmd_pkg.sv
// Shared MIDI/synth command definitions: status nibbles, reserved codes,
// command field layout and parser encodings.
package synth_cmd_pkg;

    localparam logic [3:0] ST_NOTE_OFF = 4'h8;
    localparam logic [3:0] ST_NOTE_ON  = 4'h9;
    localparam logic [3:0] ST_CC       = 4'hB;
    localparam logic [3:0] ST_PROG     = 4'hC;
    localparam logic [3:0] ST_CHPRESS  = 4'hD;

    localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;
    localparam logic [6:0] NOTE_STOP_ALL    = 7'h7F;

    localparam int CMD_W        = 16;
    localparam int CMD_ON_BIT   = 15;
    localparam int CMD_NOTE_MSB = 14;
    localparam int CMD_NOTE_LSB = 8;
    localparam int CMD_VEL_MSB  = 7;
    localparam int CMD_VEL_LSB  = 0;

    typedef enum logic [1:0] {
        PS_IDLE    = 2'd0,
        PS_WAIT_D1 = 2'd1,
        PS_WAIT_D2 = 2'd2
    } parse_state_e;

    typedef enum logic [2:0] {
        K_NONE     = 3'd0,
        K_NOTE_ON  = 3'd1,
        K_NOTE_OFF = 3'd2,
        K_CC       = 3'd3,
        K_OTHER2   = 3'd4,
        K_OTHER1   = 3'd5
    } kind_e;

    function automatic logic [CMD_W-1:0] make_cmd(input logic on,
                                                  input logic [6:0] note,
                                                  input logic [7:0] vel);
        logic [CMD_W-1:0] cmd;
        cmd                            = '0;
        cmd[CMD_ON_BIT]                = on;
        cmd[CMD_NOTE_MSB:CMD_NOTE_LSB] = note;
        cmd[CMD_VEL_MSB:CMD_VEL_LSB]   = vel;
        return cmd;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO with show-ahead head output and occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign empty_o   = (count_q == '0);
    assign do_push_s = push_i && (count_q != DEPTH_C);
    assign do_pop_s  = pop_i && !empty_o;
    assign head_o    = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/midi_note_master.sv
// MIDI byte-stream parser that queues note commands and issues them as
// Avalon-MM writes to the synthesizer note-command slave.
module midi_note_master
    import synth_cmd_pkg::*;
#(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] CHANNEL    = 4'd0,
    parameter bit         OMNI       = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  i_midi_data,
    input  logic        i_midi_valid,
    output logic        o_midi_ready,
    output logic        avm_m0_write,
    output logic [31:0] avm_m0_writedata,
    input  logic        avm_m0_waitrequest,
    output logic [7:0]  o_drop_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    parse_state_e     state_q, state_d;
    kind_e            kind_q, kind_d;
    kind_e            chan_kind_s;
    logic [6:0]       d1_q, d1_d;
    logic [7:0]       drop_q, drop_d;
    logic             accept_s, is_rt_s, is_sys_s, is_chan_s, is_data_s, chan_match_s;
    logic             push_s, drop_inc_s, pop_s, fifo_empty_s;
    logic [CMD_W-1:0] cmd_s, fifo_head_s;
    logic [CW-1:0]    fifo_count_s;

    assign o_midi_ready = (fifo_count_s < DEPTH_C);
    assign accept_s     = i_midi_valid && o_midi_ready;
    assign is_data_s    = !i_midi_data[7];
    assign is_rt_s      = (i_midi_data[7:3] == 5'b11111);
    assign is_sys_s     = (i_midi_data[7:4] == 4'hF) && !is_rt_s;
    assign is_chan_s    = i_midi_data[7] && (i_midi_data[7:4] != 4'hF);
    assign chan_match_s = OMNI || (i_midi_data[3:0] == CHANNEL);

    // Map a channel voice status to its kind; foreign channels keep only the length.
    always_comb begin
        chan_kind_s = K_OTHER2;
        case (i_midi_data[7:4])
            ST_NOTE_OFF:         chan_kind_s = chan_match_s ? K_NOTE_OFF : K_OTHER2;
            ST_NOTE_ON:          chan_kind_s = chan_match_s ? K_NOTE_ON  : K_OTHER2;
            ST_CC:               chan_kind_s = chan_match_s ? K_CC       : K_OTHER2;
            ST_PROG, ST_CHPRESS: chan_kind_s = K_OTHER1;
            default:             chan_kind_s = K_OTHER2;
        endcase
    end

    // Parser state, running-status kind and latched D1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= PS_IDLE;
            kind_q  <= K_NONE;
            d1_q    <= 7'd0;
            drop_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            kind_q  <= kind_d;
            d1_q    <= d1_d;
            drop_q  <= drop_d;
        end
    end

    // Next-state logic; real-time bytes fall through and leave everything intact.
    always_comb begin
        state_d = state_q;
        kind_d  = kind_q;
        d1_d    = d1_q;
        if (accept_s && !is_rt_s) begin
            if (is_sys_s) begin
                state_d = PS_IDLE;
                kind_d  = K_NONE;
            end else if (is_chan_s) begin
                state_d = PS_WAIT_D1;
                kind_d  = chan_kind_s;
            end else begin
                case (state_q)
                    PS_IDLE, PS_WAIT_D1: begin
                        if (kind_q != K_NONE) begin
                            d1_d    = i_midi_data[6:0];
                            state_d = (kind_q == K_OTHER1) ? PS_IDLE : PS_WAIT_D2;
                        end else begin
                            state_d = PS_IDLE;
                        end
                    end
                    PS_WAIT_D2: state_d = PS_IDLE;
                    default:    state_d = PS_IDLE;
                endcase
            end
        end else begin
            state_d = state_q;
        end
    end

    // Emit and drop decisions on the byte that completes (or orphans) a message.
    always_comb begin
        push_s     = 1'b0;
        drop_inc_s = 1'b0;
        cmd_s      = '0;
        if (accept_s && is_data_s && (state_q == PS_WAIT_D2)) begin
            case (kind_q)
                K_NOTE_ON, K_NOTE_OFF: begin
                    if (d1_q == NOTE_STOP_ALL) begin
                        drop_inc_s = 1'b1;
                    end else begin
                        push_s = 1'b1;
                        cmd_s  = make_cmd((kind_q == K_NOTE_ON) && (i_midi_data != 8'h00),
                                          d1_q, i_midi_data);
                    end
                end
                K_CC: begin
                    if (d1_q == CC_ALL_NOTES_OFF) begin
                        push_s = 1'b1;
                        cmd_s  = make_cmd(1'b0, NOTE_STOP_ALL, 8'h00);
                    end else begin
                        push_s = 1'b0;
                    end
                end
                default: push_s = 1'b0;
            endcase
        end else if (accept_s && is_data_s && (state_q == PS_IDLE) && (kind_q == K_NONE)) begin
            drop_inc_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    assign drop_d = (drop_inc_s && (drop_q != 8'hFF)) ? drop_q + 8'd1 : drop_q;

    cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .push_i  (push_s),
        .data_i  (cmd_s),
        .pop_i   (pop_s),
        .head_o  (fifo_head_s),
        .count_o (fifo_count_s),
        .empty_o (fifo_empty_s)
    );

    assign avm_m0_write     = !fifo_empty_s;
    assign pop_s            = avm_m0_write && !avm_m0_waitrequest;
    assign avm_m0_writedata = {16'h0000, fifo_empty_s ? 16'h0000 : fifo_head_s};
    assign o_drop_cnt       = drop_q;

endmodule

// File: doc/midi_note_master.md
# midi_note_master

- Parses a MIDI byte stream from the MIDI UART receiver into 16-bit note commands.
- Issues those commands as Avalon-MM writes to the synthesizer's note-command slave port.
- The command format is {on, note[6:0], velocity[7:0]} in writedata[15:0], with note 7'h7F reserved as STOP_ALL.
- A small command FIFO decouples byte arrival from slave backpressure.

## Interface

Parameters:
- FIFO_DEPTH, 4: command FIFO entries; power of two, ≥2.
- CHANNEL, 4'd0: MIDI channel accepted.
- OMNI, 0: 1 = accept all channels.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- i_midi_data  in  8  received MIDI byte.
- i_midi_valid  in  1  byte valid; a byte is accepted when valid && ready.
- o_midi_ready  out  1  high when FIFO count < FIFO_DEPTH.
- avm_m0_write  out  1  write request.
- avm_m0_writedata  out  32  {16'b0, command}.
- avm_m0_waitrequest  in  1  slave stall.
- o_drop_cnt  out  8  saturating count of discarded data bytes and reserved-note events.

## Operation

**Byte classes**
- Status byte: bit7 = 1.
- Data byte: bit7 = 0.
- Real-time bytes (F8–FF) are accepted and ignored. They leave all parser state untouched, even mid-message.

**Parser FSM: IDLE, WAIT_D1, WAIT_D2**
- The running-status register holds the kind: NOTE_ON, NOTE_OFF, CC, OTHER2, OTHER1 or NONE.
- Channel voice status (80–EF):
  - Sets the kind. Status bytes for other channels set OTHER2 or OTHER1 according to message length.
  - Next state is WAIT_D1.
- System common (F0–F7): kind becomes NONE, state becomes IDLE.
- IDLE + data byte, kind NONE: the byte is dropped and o_drop_cnt increments.
- IDLE + data byte, kind not NONE (running status): the byte is treated as D1.
- WAIT_D1 + data byte:
  - Latch D1.
  - For OTHER1 (Cx/Dx) the message is complete and is discarded; go to IDLE.
  - Otherwise go to WAIT_D2.
- WAIT_D2 + data byte: the message is complete; emit per the rules below, then go to IDLE.
- A status byte in WAIT_D1 or WAIT_D2 aborts the partial message and is processed as a new status.

**Emit rules** (D1 = note or controller, D2 = velocity or value)
- NOTE_ON, D2 ≠ 0: push {1, D1, D2}.
- NOTE_ON, D2 = 0: push {0, D1, 8'h00}.
- NOTE_OFF: push {0, D1, D2}.
- CC with D1 = 123 (All Notes Off): push {0, 7'h7F, 8'h00} (STOP_ALL).
- Other CC, OTHER2: no push.
- Note events with D1 = 7'h7F: not pushed; o_drop_cnt increments.

**Avalon master**
- avm_m0_write = FIFO not empty.
- writedata = FIFO head.
- Pop on avm_m0_write && !avm_m0_waitrequest.
- While waitrequest is high, write and writedata stay stable.

## Timing

**Reset values**
- avm_m0_write 0, avm_m0_writedata 0, o_drop_cnt 0.
- o_midi_ready 1 once reset is deasserted.
- FSM IDLE, kind NONE, FIFO empty.

**Reset mid-operation**
- Asynchronous: write drops immediately.
- Any pending FIFO entries and partial messages are lost.

**Latency**
- The completing byte is accepted on edge k and pushed on edge k.
- avm_m0_write is high after edge k, so the earliest slave capture is edge k+1.

**FIFO behaviour**
- Back-to-back pops: one command per cycle when waitrequest is low.
- Simultaneous push and pop when not full: count unchanged and order preserved.
- Full: o_midi_ready is low and no byte is accepted.
- A push can only occur when an accepted byte completes a message, so overflow is impossible.

**Other boundaries**
- Pointers wrap modulo FIFO_DEPTH.
- o_drop_cnt saturates at 255.

## Structure

**Shared package synth_cmd_pkg**
- MIDI status nibbles (8, 9, B, C, D).
- CC_ALL_NOTES_OFF = 123.
- NOTE_STOP_ALL = 7'h7F.
- Command field positions: ON bit 15, NOTE 14:8, VEL 7:0.
- Parser state and kind encodings.

This package is shared with the synthesizer command decoder.

**Sub-module**
- One sub-module, cmd_fifo: parameterised synchronous FIFO with show-ahead head and count output.

## Test plan

1. Bytes 90 5B 64 with waitrequest low → one write with writedata 0x0000DB64 one cycle after the 64 byte; the FIFO then empties.
2. Running status: 90 45 40 45 00 → writes 0x0000C540 then 0x00004500.
3. waitrequest held high for 10 cycles with 5 commands queued (FIFO_DEPTH = 4):
   - o_midi_ready drops after 4 commands.
   - writedata stays stable throughout.
   - After release, 4 writes are accepted back-to-back in order, then the 5th.
4. Filtering, CHANNEL = 0:
   - 91 3C 40 (channel 1) → no write.
   - B0 7B 00 → 0x00007F00.
   - 80 7F 10 → no write, o_drop_cnt = 1.
5. Stray and interleaved bytes:
   - 3C after reset → o_drop_cnt = 1, no write.
   - 90 F8 3C F8 40 → single write 0x0000BC40.
6. Reset asserted while avm_m0_write is high with 3 entries queued → write = 0 immediately; no writes after release until new bytes arrive.
